opb_register_bank_s2p: RTL and testbench

OPB_REGISTER_BANK_S2P -- requirements
Module: opb_register_bank_s2p

---
 rtl/opb_register_bank_s2p.sv | 185 ++++++++++++++++++
 tb/tb_opb_register_bank_s2p.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/opb_register_bank_s2p.sv
// OPB slave register bank: user-side channels captured into read-only DATA registers,
// with fresh/overrun status, freeze/clear control and a running capture counter.
module opb_register_bank_s2p #(
    parameter logic [31:0] C_BASEADDR = 32'h0100E100,
    parameter logic [31:0] C_HIGHADDR = 32'h0100E1FF,
    parameter int          C_NUM_REGS = 4
) (
    input  logic                      OPB_Clk,
    input  logic                      OPB_Rst,
    input  logic [0:31]               OPB_ABus,
    input  logic [0:3]                OPB_BE,
    input  logic [0:31]               OPB_DBus,
    input  logic                      OPB_RNW,
    input  logic                      OPB_select,
    input  logic                      OPB_seqAddr,
    output logic [0:31]               Sl_DBus,
    output logic                      Sl_xferAck,
    output logic                      Sl_errAck,
    output logic                      Sl_retry,
    output logic                      Sl_toutSup,
    input  logic [C_NUM_REGS*32-1:0]  user_data_in,
    input  logic [C_NUM_REGS-1:0]     user_valid
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [31:0] OFF_STATUS  = 32'(C_NUM_REGS);
    localparam logic [31:0] OFF_CONTROL = 32'(C_NUM_REGS + 1);
    localparam logic [31:0] OFF_CAPCNT  = 32'(C_NUM_REGS + 2);

    function automatic logic [31:0] popcount(input logic [C_NUM_REGS-1:0] v);
        logic [31:0] cnt;
        cnt = 32'd0;
        for (int i = 0; i < C_NUM_REGS; i++) begin
            cnt = cnt + {31'd0, v[i]};
        end
        return cnt;
    endfunction

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic                    xfer_done_r;
    logic                    rnw_r;
    logic [31:0]             off_r;
    logic [31:0]             data_r [C_NUM_REGS];
    logic [C_NUM_REGS-1:0]   fresh_r;
    logic [C_NUM_REGS-1:0]   ovr_r;
    logic                    freeze_r;
    logic [31:0]             capcnt_r;

    logic [31:0]             abus_s;
    logic [31:0]             wdata_s;
    logic [31:0]             diff_s;
    logic [31:0]             off_s;
    logic [31:0]             rdata_s;
    logic [31:0]             dbus_s;
    logic                    hit_s;
    logic                    start_s;
    logic                    ack_s;
    logic                    wr_s;
    logic                    status_wr_s;
    logic                    ctrl_wr_s;
    logic [C_NUM_REGS-1:0]   cap_s;
    logic [C_NUM_REGS-1:0]   rd_clr_s;
    logic [C_NUM_REGS-1:0]   ovr_clr_s;
    logic [C_NUM_REGS-1:0]   fresh_nxt_s;
    logic [C_NUM_REGS-1:0]   ovr_nxt_s;
    logic [31:0]             cap_pop_s;
    logic                    unused_s;

    assign abus_s  = OPB_ABus;
    assign wdata_s = OPB_DBus;
    assign diff_s  = abus_s - C_BASEADDR;
    assign off_s   = {2'b00, diff_s[31:2]};
    assign hit_s   = OPB_select && (abus_s >= C_BASEADDR) && (abus_s <= C_HIGHADDR);
    // A select still held from the previous transfer must not start a new one.
    assign start_s = hit_s && !xfer_done_r;
    // Reset kills the ack combinationally so an aborted transfer is never acknowledged.
    assign ack_s   = (state_r == ST_ACK) && !OPB_Rst;

    // Bus FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) state_nxt_s = ST_ACK;
                else         state_nxt_s = ST_IDLE;
            end
            ST_ACK:  state_nxt_s = ST_HOLD;
            ST_HOLD: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Bus FSM state plus the address/direction latched at the start of a transfer.
    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            state_r     <= ST_IDLE;
            xfer_done_r <= 1'b0;
            rnw_r       <= 1'b1;
            off_r       <= 32'd0;
        end else begin
            state_r <= state_nxt_s;
            if (state_r == ST_ACK)  xfer_done_r <= 1'b1;
            else if (!OPB_select)   xfer_done_r <= 1'b0;
            if (state_r == ST_IDLE && start_s) begin
                off_r <= off_s;
                rnw_r <= OPB_RNW;
            end
        end
    end

    // Capture qualification, write strobes and next fresh/overrun flags.
    always_comb begin
        cap_s       = user_valid & {C_NUM_REGS{~freeze_r}};
        wr_s        = ack_s && !rnw_r && OPB_BE[3];
        status_wr_s = wr_s && (off_r == OFF_STATUS);
        ctrl_wr_s   = wr_s && (off_r == OFF_CONTROL);
        rd_clr_s    = {C_NUM_REGS{1'b0}};
        ovr_clr_s   = {C_NUM_REGS{1'b0}};
        for (int i = 0; i < C_NUM_REGS; i++) begin
            rd_clr_s[i]  = ack_s && rnw_r && (off_r == 32'(i));
            ovr_clr_s[i] = status_wr_s && wdata_s[16+i];
        end
        // A same-cycle capture keeps FRESH set and a new overrun beats the W1C clear.
        fresh_nxt_s = cap_s | (fresh_r & ~rd_clr_s);
        ovr_nxt_s   = (cap_s & fresh_r) | (ovr_r & ~ovr_clr_s);
        cap_pop_s   = popcount(cap_s);
    end

    // Read multiplexer over the register map; out-of-map offsets read zero.
    always_comb begin
        rdata_s = 32'd0;
        if (off_r == OFF_STATUS) begin
            for (int i = 0; i < C_NUM_REGS; i++) begin
                rdata_s[i]    = fresh_r[i];
                rdata_s[16+i] = ovr_r[i];
            end
        end else if (off_r == OFF_CONTROL) begin
            rdata_s = {31'd0, freeze_r};
        end else if (off_r == OFF_CAPCNT) begin
            rdata_s = capcnt_r;
        end else begin
            for (int i = 0; i < C_NUM_REGS; i++) begin
                rdata_s = (off_r == 32'(i)) ? data_r[i] : rdata_s;
            end
        end
    end

    assign dbus_s     = (ack_s && rnw_r) ? rdata_s : 32'd0;
    assign Sl_DBus    = dbus_s;
    assign Sl_xferAck = ack_s;
    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;

    // Channel data, status flags, control and capture counter.
    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            for (int i = 0; i < C_NUM_REGS; i++) begin
                data_r[i] <= 32'd0;
            end
            fresh_r  <= {C_NUM_REGS{1'b0}};
            ovr_r    <= {C_NUM_REGS{1'b0}};
            freeze_r <= 1'b0;
            capcnt_r <= 32'd0;
        end else begin
            for (int i = 0; i < C_NUM_REGS; i++) begin
                if (cap_s[i]) data_r[i] <= user_data_in[32*i +: 32];
            end
            fresh_r <= fresh_nxt_s;
            ovr_r   <= ovr_nxt_s;
            if (ctrl_wr_s) freeze_r <= wdata_s[0];
            if (ctrl_wr_s && wdata_s[1]) capcnt_r <= cap_pop_s;
            else                         capcnt_r <= capcnt_r + cap_pop_s;
        end
    end

    assign unused_s = ^{OPB_seqAddr, OPB_BE[0:2], diff_s[1:0], wdata_s};

endmodule

// File: tb/tb_opb_register_bank_s2p.sv
// Self-checking bench for opb_register_bank_s2p: directed scenarios plus randomized
// traffic compared against a register-level reference model.
module tb_opb_register_bank_s2p;

    localparam logic [31:0] BASE = 32'h0100E100;

    logic          OPB_Clk = 1'b0;
    logic          OPB_Rst = 1'b1;
    logic [0:31]   OPB_ABus = 32'd0;
    logic [0:3]    OPB_BE = 4'd0;
    logic [0:31]   OPB_DBus = 32'd0;
    logic          OPB_RNW = 1'b1;
    logic          OPB_select = 1'b0;
    logic          OPB_seqAddr = 1'b0;
    logic [0:31]   Sl_DBus;
    logic          Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup;
    logic [127:0]  user_data_in = 128'd0;
    logic [3:0]    user_valid = 4'd0;

    int tests = 0;
    int fails = 0;

    // reference model state
    logic [31:0] m_data [4];
    logic [3:0]  m_fresh = 4'd0;
    logic [3:0]  m_ovr = 4'd0;
    logic        m_freeze = 1'b0;
    logic [31:0] m_cnt = 32'd0;

    opb_register_bank_s2p dut (
        .OPB_Clk(OPB_Clk), .OPB_Rst(OPB_Rst), .OPB_ABus(OPB_ABus), .OPB_BE(OPB_BE),
        .OPB_DBus(OPB_DBus), .OPB_RNW(OPB_RNW), .OPB_select(OPB_select),
        .OPB_seqAddr(OPB_seqAddr), .Sl_DBus(Sl_DBus), .Sl_xferAck(Sl_xferAck),
        .Sl_errAck(Sl_errAck), .Sl_retry(Sl_retry), .Sl_toutSup(Sl_toutSup),
        .user_data_in(user_data_in), .user_valid(user_valid)
    );

    always #5 OPB_Clk = ~OPB_Clk;

    function automatic logic [31:0] exp_read(input int off);
        if (off < 4)       return m_data[off];
        else if (off == 4) return {12'd0, m_ovr, 12'd0, m_fresh};
        else if (off == 5) return {31'd0, m_freeze};
        else if (off == 6) return m_cnt;
        else               return 32'd0;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One clock cycle: apply user inputs, advance the model, step past the edge.
    task automatic cycle(input logic [3:0] uv, input logic [127:0] ud, input bit acked,
                         input bit rd, input int off, input logic [31:0] wd, input bit be3);
        logic [3:0] cap;
        logic [3:0] fresh_n;
        logic [3:0] ovr_n;
        int pop;
        user_valid   = uv;
        user_data_in = ud;
        if (OPB_Rst) begin
            for (int i = 0; i < 4; i++) m_data[i] = 32'd0;
            m_fresh = 4'd0; m_ovr = 4'd0; m_freeze = 1'b0; m_cnt = 32'd0;
        end else begin
            cap = m_freeze ? 4'd0 : uv;
            pop = $countones(cap);
            fresh_n = m_fresh;
            ovr_n = m_ovr;
            if (acked && rd && off < 4) fresh_n[off] = 1'b0;
            if (acked && !rd && be3 && off == 4) ovr_n = ovr_n & ~wd[19:16];
            ovr_n = ovr_n | (cap & m_fresh);
            fresh_n = fresh_n | cap;
            for (int i = 0; i < 4; i++) if (cap[i]) m_data[i] = ud[i*32 +: 32];
            if (acked && !rd && be3 && off == 5 && wd[1]) m_cnt = 32'(pop);
            else m_cnt = m_cnt + 32'(pop);
            if (acked && !rd && be3 && off == 5) m_freeze = wd[0];
            m_fresh = fresh_n;
            m_ovr = ovr_n;
        end
        @(posedge OPB_Clk);
        #1;
    endtask

    task automatic idle(input logic [3:0] uv, input logic [127:0] ud);
        cycle(uv, ud, 1'b0, 1'b1, 0, 32'd0, 1'b0);
    endtask

    // Full single transfer: hit cycle, ack cycle (with optional capture), hold, idle.
    task automatic bus_xfer(input bit rd, input int off, input logic [31:0] wd, input bit be3,
                            input logic [3:0] uv_ack, input logic [127:0] ud_ack,
                            output logic [31:0] rdata);
        logic [31:0] exp;
        OPB_select = 1'b1;
        OPB_ABus   = BASE + 32'(off) * 32'd4;
        OPB_RNW    = rd;
        OPB_DBus   = wd;
        OPB_BE     = be3 ? 4'b1111 : 4'b1110;
        tests++;
        if (Sl_xferAck !== 1'b0) begin
            fails++; $display("FAIL ack_before_hit off=%0d got=%b want=0", off, Sl_xferAck);
        end
        idle(4'd0, user_data_in);
        exp = rd ? exp_read(off) : 32'd0;
        tests++;
        if (Sl_xferAck !== 1'b1) begin
            fails++; $display("FAIL ack_pulse off=%0d got=%b want=1", off, Sl_xferAck);
        end
        tests++;
        if (Sl_DBus !== exp) begin
            fails++; $display("FAIL read_data rd=%0d off=%0d got=%h want=%h", rd, off, Sl_DBus, exp);
        end
        tests++;
        if ({Sl_errAck, Sl_retry, Sl_toutSup} !== 3'b000) begin
            fails++; $display("FAIL err_retry_tout got=%b want=000", {Sl_errAck, Sl_retry, Sl_toutSup});
        end
        rdata = Sl_DBus;
        cycle(uv_ack, ud_ack, 1'b1, rd, off, wd, be3);
        OPB_select = 1'b0;
        OPB_RNW    = 1'b1;
        OPB_DBus   = 32'd0;
        tests++;
        if (Sl_xferAck !== 1'b0 || Sl_DBus !== 32'd0) begin
            fails++; $display("FAIL hold_quiet got ack=%b data=%h want ack=0 data=0", Sl_xferAck, Sl_DBus);
        end
        idle(4'd0, user_data_in);
    endtask

    task automatic read_all_zero(input string tag);
        logic [31:0] r;
        for (int k = 0; k < 7; k++) begin
            bus_xfer(1'b1, k, 32'd0, 1'b1, 4'd0, 128'd0, r);
            tests++;
            if (r !== 32'd0) begin
                fails++; $display("FAIL %s off=%0d got=%h want=00000000", tag, k, r);
            end
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            idle(4'hF, rand128());
            tests++;
            if (Sl_xferAck !== 1'b0 || Sl_DBus !== 32'd0) begin
                fails++; $display("FAIL reset_outputs got ack=%b data=%h want 0/0", Sl_xferAck, Sl_DBus);
            end
        end
        OPB_Rst = 1'b0;
        idle(4'd0, 128'd0);
        read_all_zero("reset_regs");
    endtask

    task automatic test_capture_read();
        logic [127:0] ud;
        logic [31:0] r;
        ud = rand128();
        ud[63:32] = 32'hDEADBEEF;
        idle(4'b0010, ud);
        idle(4'd0, ud);
        bus_xfer(1'b1, 4, 32'd0, 1'b1, 4'd0, ud, r);
        tests++;
        if (r !== 32'h00000002) begin fails++; $display("FAIL status_fresh got=%h want=00000002", r); end
        bus_xfer(1'b1, 1, 32'd0, 1'b1, 4'd0, ud, r);
        tests++;
        if (r !== 32'hDEADBEEF) begin fails++; $display("FAIL data1 got=%h want=DEADBEEF", r); end
        bus_xfer(1'b1, 4, 32'd0, 1'b1, 4'd0, ud, r);
        tests++;
        if (r !== 32'h00000000) begin fails++; $display("FAIL status_cleared got=%h want=00000000", r); end
    endtask

    task automatic test_overrun();
        logic [31:0] r;
        idle(4'b0001, rand128());
        idle(4'b0001, rand128());
        idle(4'd0, 128'd0);
        bus_xfer(1'b1, 4, 32'd0, 1'b1, 4'd0, 128'd0, r);
        tests++;
        if (r !== 32'h00010001) begin fails++; $display("FAIL status_ovr got=%h want=00010001", r); end
        bus_xfer(1'b0, 4, 32'h00010000, 1'b1, 4'd0, 128'd0, r);
        bus_xfer(1'b1, 4, 32'd0, 1'b1, 4'd0, 128'd0, r);
        tests++;
        if (r !== 32'h00000001) begin fails++; $display("FAIL status_w1c got=%h want=00000001", r); end
    endtask

    task automatic test_freeze();
        logic [31:0] snap [4];
        logic [31:0] snap_cnt;
        logic [31:0] r;
        bus_xfer(1'b0, 5, 32'd1, 1'b1, 4'd0, 128'd0, r);
        for (int i = 0; i < 4; i++) snap[i] = m_data[i];
        snap_cnt = m_cnt;
        idle(4'hF, rand128());
        idle(4'd0, 128'd0);
        for (int i = 0; i < 4; i++) begin
            bus_xfer(1'b1, i, 32'd0, 1'b1, 4'd0, 128'd0, r);
            tests++;
            if (r !== snap[i]) begin fails++; $display("FAIL frozen_data%0d got=%h want=%h", i, r, snap[i]); end
        end
        bus_xfer(1'b1, 6, 32'd0, 1'b1, 4'd0, 128'd0, r);
        tests++;
        if (r !== snap_cnt) begin fails++; $display("FAIL frozen_cnt got=%h want=%h", r, snap_cnt); end
        bus_xfer(1'b0, 5, 32'd0, 1'b1, 4'd0, 128'd0, r);
        idle(4'hF, rand128());
        idle(4'd0, 128'd0);
        bus_xfer(1'b1, 6, 32'd0, 1'b1, 4'd0, 128'd0, r);
        tests++;
        if (r !== snap_cnt + 32'd4) begin fails++; $display("FAIL cnt_plus4 got=%h want=%h", r, snap_cnt + 32'd4); end
    endtask

    task automatic test_collision();
        logic [127:0] ud_a;
        logic [127:0] ud_b;
        logic [31:0] r;
        ud_a = rand128();
        ud_b = rand128();
        idle(4'b0100, ud_a);
        idle(4'd0, ud_a);
        bus_xfer(1'b1, 2, 32'd0, 1'b1, 4'b0100, ud_b, r);
        tests++;
        if (r !== ud_a[95:64]) begin fails++; $display("FAIL collide_old got=%h want=%h", r, ud_a[95:64]); end
        bus_xfer(1'b1, 4, 32'd0, 1'b1, 4'd0, ud_b, r);
        tests++;
        if (r[2] !== 1'b1) begin fails++; $display("FAIL collide_fresh2 got=%b want=1", r[2]); end
        bus_xfer(1'b1, 2, 32'd0, 1'b1, 4'd0, ud_b, r);
        tests++;
        if (r !== ud_b[95:64]) begin fails++; $display("FAIL collide_new got=%h want=%h", r, ud_b[95:64]); end
    endtask

    task automatic test_long_select();
        int pulses;
        logic [31:0] r;
        pulses = 0;
        OPB_select = 1'b1;
        OPB_ABus   = BASE + 32'd40;
        OPB_RNW    = 1'b1;
        OPB_BE     = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            cycle(4'd0, 128'd0, k == 1, 1'b1, 10, 32'd0, 1'b1);
            if (Sl_xferAck === 1'b1) pulses++;
        end
        OPB_select = 1'b0;
        idle(4'd0, 128'd0);
        tests++;
        if (pulses != 1) begin fails++; $display("FAIL long_select_pulses got=%0d want=1", pulses); end
        bus_xfer(1'b1, 10, 32'd0, 1'b1, 4'd0, 128'd0, r);
        tests++;
        if (r !== 32'd0) begin fails++; $display("FAIL off10_zero got=%h want=00000000", r); end
    endtask

    task automatic test_random();
        logic [31:0] r;
        logic [31:0] wd;
        int off;
        bit rd;
        for (int n = 0; n < 60; n++) begin
            for (int c = 0; c < $urandom_range(0, 2); c++) idle(4'($urandom), rand128());
            off = $urandom_range(0, 12);
            rd  = 1'($urandom_range(0, 1));
            wd  = (off == 5) ? ($urandom & 32'h3) : $urandom;
            bus_xfer(rd, off, wd, 1'($urandom_range(0, 1)), 4'($urandom), rand128(), r);
        end
    endtask

    task automatic test_reset_in_ack();
        idle(4'hF, rand128());
        OPB_select = 1'b1;
        OPB_ABus   = BASE + 32'd20;
        OPB_RNW    = 1'b0;
        OPB_DBus   = 32'd3;
        OPB_BE     = 4'b1111;
        idle(4'd0, 128'd0);
        tests++;
        if (Sl_xferAck !== 1'b1) begin fails++; $display("FAIL pre_reset_ack got=%b want=1", Sl_xferAck); end
        OPB_Rst = 1'b1;
        #1;
        tests++;
        if (Sl_xferAck !== 1'b0 || Sl_DBus !== 32'd0) begin
            fails++; $display("FAIL reset_in_ack got ack=%b data=%h want 0/0", Sl_xferAck, Sl_DBus);
        end
        idle(4'hF, rand128());
        OPB_Rst    = 1'b0;
        OPB_select = 1'b0;
        OPB_RNW    = 1'b1;
        OPB_DBus   = 32'd0;
        idle(4'd0, 128'd0);
        read_all_zero("after_abort");
    endtask

    initial begin
        for (int i = 0; i < 4; i++) m_data[i] = 32'd0;
        test_reset();
        test_capture_read();
        test_overrun();
        test_freeze();
        test_collision();
        test_long_select();
        test_random();
        test_reset_in_ack();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
